// File: rtl/scan_pkg.sv
// scan_pkg: shared definitions for the channel scanner.
//   scan_state_t    - scanner FSM states (IDLE, SCAN, DONE)
//   DEFAULT_SETTLE  - default number of extra settle cycles per channel
//   NUM_CHANNELS    - channels behind the downstream 4:1 mux
//   cnt_width()     - dwell counter width for a given settle value (min 1 bit)
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  localparam int DEFAULT_SETTLE = 2;
  localparam int NUM_CHANNELS   = 4;

  // $clog2(1) is 0, so a settle of 0 still needs a one-bit counter.
  function automatic int cnt_width(input int settle);
    return (settle > 0) ? $clog2(settle + 1) : 1;
  endfunction

endpackage

// File: rtl/channel_scanner_settle_counter.sv
// settle_counter: dwell counter for one mux channel slot.
// Ports:
//   clk      in  clock
//   rst_n    in  asynchronous active-low reset
//   clear    in  synchronous clear to 0 (wins over enable)
//   enable   in  count up by one
//   terminal out high while the count equals SETTLE
module settle_counter
  import scan_pkg::*;
#(
  parameter int SETTLE = DEFAULT_SETTLE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int W = cnt_width(SETTLE);
  localparam logic [W-1:0] TERM = W'(SETTLE);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] count_r;

  // Dwell count register: clear has priority over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign terminal = (count_r == TERM);

endmodule

// File: rtl/channel_scanner.sv
// channel_scanner: steps a 4:1 mux select through all channels, holds each
// select for SETTLE+1 cycles, samples w on the last cycle of each slot and
// presents the four samples as one word through a valid/ready handshake.
// Ports:
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset
//   start  in  request one scan (only looked at in IDLE)
//   w      in  mux output, synchronous to clk
//   s0,s1  out mux select, straight from the select register
//   busy   out high in SCAN and DONE
//   data   out captured word, bit i = w seen with select i
//   valid  out data holds a completed scan
//   ready  in  consumer takes data when valid && ready
module channel_scanner
  import scan_pkg::*;
#(
  parameter int SETTLE = DEFAULT_SETTLE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       w,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic [3:0] data,
  output logic       valid,
  input  logic       ready
);

  scan_state_t state_r;
  logic [1:0]  sel_r;
  logic [3:0]  data_buf_r;
  logic [3:0]  buf_next_s;
  logic        terminal_s;
  logic        cnt_clear_s;
  logic        cnt_enable_s;

  // The counter only runs in SCAN and restarts at every capture, so it is
  // already zero on the first SCAN cycle of each channel.
  assign cnt_enable_s = (state_r == SCAN);
  assign cnt_clear_s  = (state_r != SCAN) || terminal_s;

  settle_counter #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (cnt_clear_s),
    .enable   (cnt_enable_s),
    .terminal (terminal_s)
  );

  // Buffer with the current sample merged in; used so the final channel
  // reaches data on the same edge it is captured.
  always_comb begin
    buf_next_s        = data_buf_r;
    buf_next_s[sel_r] = w;
  end

  // Select goes to the mux without any decode so it cannot glitch.
  assign s0 = sel_r[0];
  assign s1 = sel_r[1];

  // Scanner FSM with registered busy/valid/data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      sel_r      <= 2'd0;
      data_buf_r <= 4'd0;
      data       <= 4'd0;
      valid      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= SCAN;
            sel_r   <= 2'd0;
            busy    <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        SCAN: begin
          if (terminal_s) begin
            data_buf_r <= buf_next_s;
            if (sel_r == 2'd3) begin
              state_r <= DONE;
              valid   <= 1'b1;
              data    <= buf_next_s;
            end else begin
              sel_r <= sel_r + 2'd1;
            end
          end else begin
            state_r <= SCAN;
          end
        end
        DONE: begin
          // start is deliberately ignored here, even on the accept edge.
          if (valid && ready) begin
            state_r <= IDLE;
            valid   <= 1'b0;
            busy    <= 1'b0;
            sel_r   <= 2'd0;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r <= IDLE;
          sel_r   <= 2'd0;
          valid   <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_channel_scanner.sv
// Directed bench for channel_scanner. Two instances: SETTLE=2 (dut2) and
// SETTLE=0 (dut0), each feeding w from a gate-level NAND 4:1 mux model.
module tb_channel_scanner;

  logic clk;
  logic rst_n;

  logic       start2, ready2, s0_2, s1_2, busy2, valid2, w2;
  logic [3:0] data2;
  logic [3:0] ch2;   // {d,c,b,a}

  logic       start0, ready0, s0_0, s1_0, busy0, valid0, w0;
  logic [3:0] data0;
  logic [3:0] ch0;

  int checks;
  int errors;

  // NAND-only 4:1 mux: w = ch[{s1,s0}]
  function automatic logic nand_mux(input logic [3:0] ch, input logic s1, input logic s0);
    logic na, nb, nc, nd;
    na = ~(ch[0] & ~s1 & ~s0);
    nb = ~(ch[1] & ~s1 &  s0);
    nc = ~(ch[2] &  s1 & ~s0);
    nd = ~(ch[3] &  s1 &  s0);
    return ~(na & nb & nc & nd);
  endfunction

  assign w2 = nand_mux(ch2, s1_2, s0_2);
  assign w0 = nand_mux(ch0, s1_0, s0_0);

  channel_scanner #(.SETTLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .w(w2), .s0(s0_2), .s1(s1_2),
    .busy(busy2), .data(data2), .valid(valid2), .ready(ready2)
  );

  channel_scanner #(.SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .w(w0), .s0(s0_0), .s1(s1_0),
    .busy(busy0), .data(data0), .valid(valid0), .ready(ready0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start2 = 1'b0; start0 = 1'b0; ready2 = 1'b0; ready0 = 1'b0;
    ch2 = 4'b0000; ch0 = 4'b0000;
    step(); step();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if ({s1_2, s0_2, busy2, valid2, data2} !== 8'b0000_0000) begin
      errors++;
      $display("FAIL reset_idle2 got s=%b%b busy=%b valid=%b data=%b want all 0", s1_2, s0_2, busy2, valid2, data2);
    end
    checks++;
    if ({s1_0, s0_0, busy0, valid0, data0} !== 8'b0000_0000) begin
      errors++;
      $display("FAIL reset_idle0 got s=%b%b busy=%b valid=%b data=%b want all 0", s1_0, s0_0, busy0, valid0, data0);
    end
  endtask

  // a=1,b=0,c=1,d=1 -> 4'b1101; select steps every 3 cycles, valid 12 edges after start edge
  task automatic test_scan_settle2();
    ch2 = 4'b1101;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    checks++;
    if ({s1_2, s0_2, busy2, valid2} !== 4'b0010) begin
      errors++;
      $display("FAIL scan2_enter got s=%b%b busy=%b valid=%b want s=00 busy=1 valid=0", s1_2, s0_2, busy2, valid2);
    end
    for (int k = 1; k < 12; k++) begin
      logic [1:0] exp_sel;
      step();
      exp_sel = 2'(k / 3);
      checks++;
      if ({s1_2, s0_2} !== exp_sel || valid2 !== 1'b0 || busy2 !== 1'b1) begin
        errors++;
        $display("FAIL scan2_step%0d got s=%b%b valid=%b busy=%b want s=%b valid=0 busy=1", k, s1_2, s0_2, valid2, busy2, exp_sel);
      end
    end
    step();
    checks++;
    if (valid2 !== 1'b1 || data2 !== 4'b1101 || {s1_2, s0_2} !== 2'b11) begin
      errors++;
      $display("FAIL scan2_done got valid=%b data=%b s=%b%b want valid=1 data=1101 s=11", valid2, data2, s1_2, s0_2);
    end
  endtask

  // DONE with ready low: everything frozen while w inputs and start toggle
  task automatic test_hold_done();
    for (int i = 0; i < 10; i++) begin
      ch2 = 4'(i * 5);
      start2 = i[0];
      step();
      checks++;
      if (valid2 !== 1'b1 || data2 !== 4'b1101 || {s1_2, s0_2} !== 2'b11 || busy2 !== 1'b1) begin
        errors++;
        $display("FAIL hold_done%0d got valid=%b data=%b s=%b%b busy=%b want valid=1 data=1101 s=11 busy=1", i, valid2, data2, s1_2, s0_2, busy2);
      end
    end
    // accept with start high: must go to IDLE and stay there
    start2 = 1'b1;
    ready2 = 1'b1;
    step();
    start2 = 1'b0;
    ready2 = 1'b0;
    checks++;
    if (valid2 !== 1'b0 || busy2 !== 1'b0 || {s1_2, s0_2} !== 2'b00 || data2 !== 4'b1101) begin
      errors++;
      $display("FAIL hold_accept got valid=%b busy=%b s=%b%b data=%b want 0 0 00 1101", valid2, busy2, s1_2, s0_2, data2);
    end
    step();
    checks++;
    if (busy2 !== 1'b0) begin
      errors++;
      $display("FAIL hold_start_ignored got busy=%b want 0", busy2);
    end
  endtask

  // SETTLE=0, a=0,b=1,c=0,d=0 -> 4'b0010, ready tied high
  task automatic test_settle0();
    ch0 = 4'b0010;
    ready0 = 1'b1;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int k = 1; k < 4; k++) begin
      step();
      checks++;
      if ({s1_0, s0_0} !== 2'(k) || valid0 !== 1'b0) begin
        errors++;
        $display("FAIL s0_step%0d got s=%b%b valid=%b want s=%0d valid=0", k, s1_0, s0_0, valid0, k);
      end
    end
    step();
    checks++;
    if (valid0 !== 1'b1 || data0 !== 4'b0010) begin
      errors++;
      $display("FAIL s0_done got valid=%b data=%b want valid=1 data=0010", valid0, data0);
    end
    step();
    checks++;
    if (valid0 !== 1'b0 || busy0 !== 1'b0 || data0 !== 4'b0010) begin
      errors++;
      $display("FAIL s0_idle got valid=%b busy=%b data=%b want 0 0 0010", valid0, busy0, data0);
    end
  endtask

  // reset in the sel=2 slot, then a full fresh scan
  task automatic test_reset_midscan();
    ch2 = 4'b1111;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int k = 1; k <= 7; k++) step();
    checks++;
    if ({s1_2, s0_2} !== 2'b10) begin
      errors++;
      $display("FAIL mid_sel got s=%b%b want 10", s1_2, s0_2);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({s1_2, s0_2, busy2, valid2, data2} !== 8'b0000_0000) begin
      errors++;
      $display("FAIL mid_reset got s=%b%b busy=%b valid=%b data=%b want all 0", s1_2, s0_2, busy2, valid2, data2);
    end
    step();
    rst_n = 1'b1;
    step();
    ch2 = 4'b0110;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int k = 1; k < 12; k++) step();
    checks++;
    if (valid2 !== 1'b0) begin
      errors++;
      $display("FAIL fresh_early got valid=%b want 0", valid2);
    end
    step();
    checks++;
    if (valid2 !== 1'b1 || data2 !== 4'b0110) begin
      errors++;
      $display("FAIL fresh_done got valid=%b data=%b want valid=1 data=0110", valid2, data2);
    end
    ready2 = 1'b1;
    step();
    ready2 = 1'b0;
  endtask

  // start held, ready high: 6-edge period (4 SCAN, 1 DONE, 1 IDLE)
  task automatic test_back_to_back();
    ch0 = 4'b1001;
    ready0 = 1'b1;
    start0 = 1'b1;
    for (int k = 0; k < 18; k++) begin
      logic exp_busy, exp_valid;
      step();
      exp_busy  = ((k % 6) != 5);
      exp_valid = ((k % 6) == 4);
      checks++;
      if (busy0 !== exp_busy || valid0 !== exp_valid) begin
        errors++;
        $display("FAIL b2b_edge%0d got busy=%b valid=%b want busy=%b valid=%b", k, busy0, valid0, exp_busy, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (data0 !== 4'b1001) begin
          errors++;
          $display("FAIL b2b_data%0d got %b want 1001", k, data0);
        end
      end
    end
    start0 = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_scan_settle2();
    test_hold_done();
    test_settle0();
    test_reset_midscan();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
